// File: rtl/snitch_icache_lookup_sched.sv
// Lookup scheduler for the Snitch instruction cache: round-robin arbitration of fetch
// requests under a credit limit, refill priority, and flush/reset invalidation sweeps.
module snitch_icache_lookup_sched #(
   parameter int unsigned NR_PORTS        = 2,
   parameter int unsigned FETCH_AW        = 32,
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned COUNT_ALIGN     = 5,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned PORT_AW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
   localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  req_addr_i,
   input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]  req_id_i,
   input  logic [NR_PORTS-1:0]                req_valid_i,
   output logic [NR_PORTS-1:0]                req_ready_o,
   output logic [FETCH_AW-1:0]                lkp_addr_o,
   output logic [ID_WIDTH-1:0]                lkp_id_o,
   output logic [PORT_AW-1:0]                 lkp_port_o,
   output logic                               lkp_valid_o,
   input  logic                               lkp_ready_i,
   input  logic                               rsp_done_i,
   input  logic                               refill_valid_i,
   output logic                               refill_ready_o,
   output logic [COUNT_ALIGN-1:0]             sweep_addr_o,
   output logic                               sweep_valid_o,
   input  logic                               sweep_ready_i,
   input  logic                               flush_valid_i,
   output logic                               flush_ready_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {SWEEP, RUN, DRAIN} state_e;

   state_e                 state, state_next;
   logic [COUNT_ALIGN-1:0] sweep_cnt, sweep_cnt_next;
   logic [CNT_W-1:0]       credits, credits_next;
   logic [PORT_AW-1:0]     rr_ptr, rr_ptr_next;
   logic [PORT_AW-1:0]     lock_port, lock_port_next;
   logic                   locked, locked_next;
   logic                   flush_pending, flush_pending_next;

   logic [PORT_AW-1:0]     grant_port, cand;
   logic                   grant_valid, transfer, sweep_hs, sweep_last;

   // Arbitration: a locked grant is always re-presented; new grants yield to refills,
   // a pending flush and an exhausted credit pool.
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = lock_port;
      cand        = '0;
      if (state == RUN) begin
         if (locked) begin
            grant_valid = 1'b1;
         end else if (!refill_valid_i && !flush_valid_i && (credits < MAX_CNT)) begin
            for (int unsigned i = 0; i < NR_PORTS; i++) begin
               cand = PORT_AW'((32'(rr_ptr) + i) % NR_PORTS);
               if (!grant_valid && req_valid_i[cand]) begin
                  grant_valid = 1'b1;
                  grant_port  = cand;
               end
            end
         end
      end
   end

   always_comb begin
      lkp_valid_o = grant_valid;
      lkp_addr_o  = grant_valid ? req_addr_i[grant_port] : '0;
      lkp_id_o    = grant_valid ? req_id_i[grant_port]   : '0;
      lkp_port_o  = grant_valid ? grant_port             : '0;
      req_ready_o = '0;
      if (grant_valid) req_ready_o[grant_port] = lkp_ready_i;
      transfer       = grant_valid & lkp_ready_i;
      refill_ready_o = (state != SWEEP) & refill_valid_i;
      sweep_valid_o  = (state == SWEEP);
      sweep_addr_o   = (state == SWEEP) ? sweep_cnt : '0;
      sweep_hs       = sweep_valid_o & sweep_ready_i;
      sweep_last     = sweep_hs & (&sweep_cnt);
      flush_ready_o  = sweep_last & flush_pending;
   end

   always_comb begin
      state_next         = state;
      sweep_cnt_next     = sweep_cnt;
      flush_pending_next = flush_pending;
      locked_next        = grant_valid & ~lkp_ready_i;
      lock_port_next     = grant_valid ? grant_port : lock_port;
      rr_ptr_next        = rr_ptr;
      credits_next       = credits;

      if (transfer)
         rr_ptr_next = (grant_port == PORT_AW'(NR_PORTS - 1)) ? '0 : grant_port + PORT_AW'(1);

      // A completion racing a new transfer leaves the count unchanged.
      if (transfer && !rsp_done_i)
         credits_next = credits + CNT_W'(1);
      else if (!transfer && rsp_done_i && (credits != '0))
         credits_next = credits - CNT_W'(1);

      unique case (state)
         SWEEP: begin
            if (sweep_last) begin
               state_next         = RUN;
               sweep_cnt_next     = '0;
               flush_pending_next = 1'b0;
            end else if (sweep_hs) begin
               sweep_cnt_next = sweep_cnt + COUNT_ALIGN'(1);
            end
         end
         RUN: begin
            if (flush_valid_i && (!locked || transfer)) begin
               state_next         = DRAIN;
               flush_pending_next = 1'b1;
            end
         end
         DRAIN: begin
            if ((credits_next == '0) && !refill_valid_i) state_next = SWEEP;
         end
         default: state_next = SWEEP;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= SWEEP;
         sweep_cnt     <= '0;
         credits       <= '0;
         rr_ptr        <= '0;
         locked        <= 1'b0;
         lock_port     <= '0;
         flush_pending <= 1'b0;
      end else begin
         state         <= state_next;
         sweep_cnt     <= sweep_cnt_next;
         credits       <= credits_next;
         rr_ptr        <= rr_ptr_next;
         locked        <= locked_next;
         lock_port     <= lock_port_next;
         flush_pending <= flush_pending_next;
      end
   end

   // A completion with nothing outstanding indicates a broken response path.
   assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_done_i && !transfer && (credits == '0)));

endmodule
